dmem_responder: RTL and testbench

- Multi-cycle data-memory responder. It sits at the far end of the MEM-stage access interface, where the EX/MEM register presents the read/write control bits, byte address and store data.
- It replaces the zero-latency data memory with a word array that takes a configurable number of cycles per access.
- It drives a stall back to the pipeline until each access completes.
- It returns load data from a register and flags misaligned accesses.

---
 rtl/dmem_responder.sv | 85 ++++++++
 tb/tb_dmem_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-array data memory that stalls the pipeline until each access completes
module dmem_responder #(
    parameter int LATENCY     = 3,
    parameter int DEPTH_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [31:0] memaddr_i,
    input  logic [31:0] writedata_i,
    output logic [31:0] memdata_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        misalign_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_n;
    logic [3:0]      cnt;
    logic            wr_q, mis_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [31:0]     mem [DEPTH_WORDS];
    logic            req, idle, acc, acc_wr, acc_mis;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic            unused_addr;

    assign unused_addr = &{1'b0, memaddr_i[31:AW+2]};
    assign req  = memread_i | memwrite_i;
    assign idle = state == IDLE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req ? (LATENCY > 1 ? BUSY : DONE) : IDLE;
            BUSY:    state_n = cnt == 4'd1 ? DONE : BUSY;
            default: state_n = IDLE;
        endcase
    end

    // With LATENCY=1 the access edge is the acceptance edge, so the live inputs are used directly
    assign acc       = !rst_i && state_n == DONE && state != DONE;
    assign acc_wr    = idle ? memwrite_i : wr_q;
    assign acc_mis   = idle ? |memaddr_i[1:0] : mis_q;
    assign acc_idx   = idle ? memaddr_i[AW+1:2] : idx_q;
    assign acc_wdata = idle ? writedata_i : wdata_q;

    assign stall_o    = !rst_i && (idle ? req : state == BUSY);
    assign ack_o      = state == DONE;
    assign misalign_o = state == DONE && mis_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            memdata_o <= '0;
            cnt       <= '0;
            wr_q      <= 1'b0;
            mis_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
        end else begin
            state <= state_n;
            if (idle && req) begin
                cnt     <= 4'(LATENCY - 1);
                wr_q    <= memwrite_i;
                mis_q   <= |memaddr_i[1:0];
                idx_q   <= memaddr_i[AW+1:2];
                wdata_q <= writedata_i;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (acc && !acc_wr)
                memdata_o <= acc_mis ? 32'h0 : mem[acc_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc && acc_wr && !acc_mis)
            mem[acc_idx] <= acc_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for LATENCY=3 and LATENCY=1 instances
module tb_dmem_responder;
    typedef struct {
        logic [31:0] d;
        logic        m;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd3, wr3, rd1, wr1;
    logic [31:0] addr3, data3, addr1, data1;
    logic [31:0] md3, md1;
    logic        st3, ack3, mis3, st1, ack1, mis1;

    dmem_responder #(.LATENCY(3), .DEPTH_WORDS(32)) dut3 (
        .clk_i(clk), .rst_i(rst), .memread_i(rd3), .memwrite_i(wr3),
        .memaddr_i(addr3), .writedata_i(data3), .memdata_o(md3),
        .stall_o(st3), .ack_o(ack3), .misalign_o(mis3));

    dmem_responder #(.LATENCY(1), .DEPTH_WORDS(32)) dut1 (
        .clk_i(clk), .rst_i(rst), .memread_i(rd1), .memwrite_i(wr1),
        .memaddr_i(addr1), .writedata_i(data1), .memdata_o(md1),
        .stall_o(st1), .ack_o(ack1), .misalign_o(mis1));

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [31:0] m3[32];
    logic [31:0] m1[32];
    logic [31:0] last3 = '0;
    logic [31:0] last1 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit one, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (one) begin rd1 = rd; wr1 = wr; addr1 = a; data1 = d; end
        else     begin rd3 = rd; wr3 = wr; addr3 = a; data3 = d; end
    endtask

    // Drives one request held until ack, as a stalled pipeline would, and checks stall length and results
    task automatic access(input string tag, input bit one, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t        e, got;
        logic [4:0]  idx;
        logic        mis;
        int          stalls;
        bit          seen;
        idx = a[6:2];
        mis = a[1:0] != 2'b00;
        if (wr) begin
            if (!mis) begin
                if (one) m1[idx] = d; else m3[idx] = d;
            end
        end else begin
            if (one) last1 = mis ? 32'h0 : m1[idx];
            else     last3 = mis ? 32'h0 : m3[idx];
        end
        e.d = one ? last1 : last3;
        e.m = mis;
        sb.push_back(e);
        @(posedge clk); #1;
        drive(one, rd, wr, a, d);
        stalls = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (one ? ack1 : ack3) begin
                seen = 1;
                break;
            end
            if (one ? st1 : st3) stalls++;
            @(posedge clk); #1;
        end
        chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            got = sb.pop_front();
            chk({tag, "_stall_cycles"}, stalls, one ? 1 : 3);
            chk({tag, "_stall_at_ack"}, 32'(one ? st1 : st3), 32'd0);
            chk({tag, "_data"}, one ? md1 : md3, got.d);
            chk({tag, "_misalign"}, 32'(one ? mis1 : mis3), 32'(got.m));
        end
        @(posedge clk); #1;
        drive(one, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk({tag, "_ack_low_after"}, 32'(one ? ack1 : ack3), 32'd0);
        chk({tag, "_misalign_low_after"}, 32'(one ? mis1 : mis3), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_md3", md3, 32'h0);
        chk("reset_ack3", 32'(ack3), 32'd0);
        chk("reset_stall3", 32'(st3), 32'd0);
        chk("reset_md1", md1, 32'h0);
        chk("reset_ack1", 32'(ack1), 32'd0);

        for (int i = 0; i < 3; i++) access("init_words", 1'b0, 1'b0, 1'b1, 32'(i * 4), 32'h01010101 * 32'(i + 1));
        access("store_deadbeef", 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access("load_deadbeef", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        access("both_bits_store", 1'b0, 1'b1, 1'b1, 32'h8, 32'h12345678);
        access("load_both", 1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
        access("mis_store", 1'b0, 1'b0, 1'b1, 32'h6, 32'hAAAA5555);
        access("word1_intact", 1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
        access("word2_intact", 1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
        access("mis_load", 1'b0, 1'b1, 1'b0, 32'h6, 32'h0);
        access("wrap_store", 1'b0, 1'b0, 1'b1, 32'h80, 32'h11);
        access("wrap_load", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'h4, 32'hCAFEF00D);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_stall_during", 32'(st3), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_stall_after", 32'(st3), 32'd0);
        chk("rst_ack_after", 32'(ack3), 32'd0);
        chk("rst_md_cleared", md3, 32'h0);
        last3 = 32'h0;
        last1 = 32'h0;
        access("load_after_abort", 1'b0, 1'b1, 1'b0, 32'h4, 32'h0);

        access("l1_init", 1'b1, 1'b0, 1'b1, 32'h20, 32'h0BADF00D);
        access("l1_load_a", 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        access("l1_store", 1'b1, 1'b0, 1'b1, 32'h20, 32'h5A5AA5A5);
        access("l1_load_b", 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        access("l1_mis_load", 1'b1, 1'b1, 1'b0, 32'h23, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
